// File: rtl/fwd_hazard_ctrl_if.sv
// Bus between the ID/EX datapath and the forwarding/hazard controller.
// The pipeline side is the master; the controller is the slave.
interface fwd_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       id_dst;
  logic             id_regwrite;
  logic             id_memread;
  logic             ex_branch_taken;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // stall/flush are purely combinational and have no handshake: they describe
  // the current cycle and take effect on the next rising clk edge.
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread,
    output ex_branch_taken,
    input  fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_regwrite, id_memread,
    input  ex_branch_taken,
    output fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use/branch hazard control for a 5-stage pipeline,
// driven from shadow copies of the EX, MEM and WB stage register fields.
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  fwd_hazard_ctrl_if.slave  bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } ex_slot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       regwrite;
  } wr_slot_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_slot_t         r_ex;
  wr_slot_t         r_mem;
  wr_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  ex_slot_t         w_ex_next;
  logic             w_flush;
  logic             w_load_hit;
  logic             w_stall;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // A stage can feed EX only when it really writes a non-zero register.
  function automatic logic wr_hit(input wr_slot_t s, input logic [4:0] r);
    return s.valid & s.regwrite & (s.dst != 5'd0) & (s.dst == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input wr_slot_t m, input wr_slot_t w,
                                         input logic [4:0] r);
    logic [1:0] sel;
    sel = 2'd0;
    if (wr_hit(m, r)) begin
      sel = 2'd2;
    end else if (wr_hit(w, r)) begin
      sel = 2'd1;
    end
    return sel;
  endfunction

  always_comb begin
    w_flush    = bus.ex_branch_taken;
    w_load_hit = r_ex.valid & r_ex.memread & (r_ex.dst != 5'd0) &
                 ((r_ex.dst == bus.id_rs) | (bus.id_uses_rt & (r_ex.dst == bus.id_rt)));
    w_stall    = bus.id_valid & w_load_hit & ~w_flush;
  end

  always_comb begin
    w_fwd_a = fwd_sel(r_mem, r_wb, r_ex.rs);
    w_fwd_b = 2'd0;
    if (r_ex.valid & r_ex.uses_rt) begin
      w_fwd_b = fwd_sel(r_mem, r_wb, r_ex.rt);
    end
  end

  // A bubble is an all-zero slot, so its rs/rt can never select a forward.
  always_comb begin
    w_ex_next = '0;
    if (!w_stall && !w_flush) begin
      w_ex_next.valid    = bus.id_valid;
      w_ex_next.rs       = bus.id_rs;
      w_ex_next.rt       = bus.id_rt;
      w_ex_next.uses_rt  = bus.id_uses_rt;
      w_ex_next.dst      = bus.id_dst;
      w_ex_next.regwrite = bus.id_regwrite;
      w_ex_next.memread  = bus.id_memread;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex           <= w_ex_next;
      r_mem.valid    <= r_ex.valid;
      r_mem.dst      <= r_ex.dst;
      r_mem.regwrite <= r_ex.regwrite;
      r_wb           <= r_mem;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.fwd_a     = w_fwd_a;
  assign bus.fwd_b     = w_fwd_b;
  assign bus.stall     = w_stall;
  assign bus.flush     = w_flush;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Clock and reset SHALL be a single clock and an asynchronous, active-high reset: clk and reset.
REQ-002 Parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_rs, id_rt  input  5 each  ID source register numbers.
REQ-007 id_uses_rt  input  1  ID instruction reads rt (R-type, store, beq).
REQ-008 id_dst  input  5  ID destination register (already rd/rt selected).
REQ-009 id_regwrite, id_memread  input  1 each  ID writes the register file, or is a load.
REQ-010 ex_branch_taken  input  1  branch in EX resolved taken this cycle.
REQ-011 fwd_a, fwd_b  output  2 each  EX operand-mux selects: 0 = register file, 1 = WB result, 2 = MEM result; 3 is never driven.
REQ-012 stall  output  1  hold PC and IF/ID this cycle.
REQ-013 flush  output  1  clear IF/ID this cycle.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-015 The block SHALL keep shadow stage registers: EX {valid, rs, rt, uses_rt, dst, regwrite, memread}, MEM {valid, dst, regwrite}, WB {valid, dst, regwrite}.
REQ-016 Every rising clk edge SHALL advance: WB<=MEM and MEM<=EX.
REQ-017 EX SHALL load the ID fields when stall=0 and flush=0; otherwise EX SHALL load a bubble (valid=0, regwrite=0, memread=0).
REQ-018 stall SHALL be combinational: 1 iff id_valid & EX.valid & EX.memread & EX.dst!=0 & (EX.dst==id_rs | (id_uses_rt & EX.dst==id_rt)), and flush=0.
REQ-019 flush SHALL equal ex_branch_taken; flush has priority over stall in the same cycle.
REQ-020 fwd_a SHALL be combinational from state: 2 if MEM.valid & MEM.regwrite & MEM.dst!=0 & MEM.dst==EX.rs; else 1 if the same condition holds for WB; else 0.
REQ-021 fwd_b SHALL use the same rule with EX.rt, and SHALL be 0 when EX.uses_rt=0 or EX.valid=0.
REQ-022 When MEM and WB both match, MEM (newest) SHALL win (select 2).
REQ-023 Register 0 SHALL never be forwarded or cause a stall.
REQ-024 A load-use hazard SHALL produce exactly one stall cycle; in the following cycle, the load is in MEM and the dependant sees fwd=2 only if not a load result. Load data is taken from WB (select 1) after the bubble, because the load has advanced to WB by the time the dependant reaches EX.
REQ-025 stall_cnt SHALL increment on each cycle with stall=1, and flush_cnt on each cycle with flush=1; both SHALL saturate at all-ones without wrapping.
REQ-026 Latency: fwd_a/fwd_b and stall SHALL be valid in the same cycle as their inputs or state, with no registered delay on outputs.

Reset
REQ-027 On reset=1, all shadow valid/regwrite/memread bits and both counters SHALL clear immediately, without waiting for clk.
REQ-028 During and after reset, fwd_a=fwd_b=0 and stall=0; flush follows ex_branch_taken.
REQ-029 Reset asserted mid-hazard SHALL drop stall in the same cycle and discard all in-flight shadow state.

Verification
REQ-030 Issue add r3 then add r4,r3,r5 back-to-back -> in the second instruction's EX cycle fwd_a=2, fwd_b=0, stall=0.
REQ-031 Issue add r3, nop, then sub r6,r1,r3 (uses_rt=1) -> fwd_b=1, fwd_a=0.
REQ-032 Issue lw r2, then add r7,r2,r2 -> stall=1 for one cycle, EX bubble inserted, then fwd_a=fwd_b=1, stall_cnt=1.
REQ-033 Issue add r8 followed by add r8 then or r9,r8,r0 -> fwd_a=2 (MEM priority over WB), fwd_b=0.
REQ-034 Present lw r2 in EX with a dependant in ID and ex_branch_taken=1 -> flush=1, stall=0, EX bubble, flush_cnt=1, stall_cnt unchanged.
REQ-035 With CNT_W=2, force 5 consecutive stall cycles and then assert reset asynchronously mid-cycle -> stall_cnt holds 3 after saturation, then clears to 0 and stall=0 before the next clk edge.
